// File: rtl/sdio_cmd_response_tx_if.sv
// sdio_cmd_response_tx_if
//   Bundles the command-processor side of the SDIO CMD response serializer.
//   master : command processor (drives payload and strobe, observes status)
//   slave  : serializer (consumes payload and strobe, drives CMD pad and status)
//   Signals:
//     write_data[37:0]          response payload, [37:32] index, [31:0] argument
//     write_data_strobe         one-cycle send request
//     send_command_in_progress  busy, capture edge through end-bit edge
//     cmd_out / cmd_oe          CMD pad data / output enable
//     tx_done                   one-cycle pulse on the line-release edge
//     overrun                   one-cycle pulse when a request is dropped
interface sdio_cmd_response_tx_if;
  logic [37:0] write_data;
  logic        write_data_strobe;
  logic        send_command_in_progress;
  logic        cmd_out;
  logic        cmd_oe;
  logic        tx_done;
  logic        overrun;

  modport master (
    output write_data,
    output write_data_strobe,
    input  send_command_in_progress,
    input  cmd_out,
    input  cmd_oe,
    input  tx_done,
    input  overrun
  );

  modport slave (
    input  write_data,
    input  write_data_strobe,
    output send_command_in_progress,
    output cmd_out,
    output cmd_oe,
    output tx_done,
    output overrun
  );
endinterface

// File: rtl/sdio_cmd_response_tx.sv
// sdio_cmd_response_tx
//   Serializes a 38-bit SDIO response payload {index, argument} onto the CMD
//   line as a 48-bit frame: start(0), direction(0), index, argument, CRC7, end(1).
//   The start bit is driven RESP_DELAY cycles after the capture edge (NCR).
//   Index 6'h3F (R4 / CMD5 response) replaces the CRC field with all ones.
//
//   Ports:
//     clock  SD clock, all logic on posedge
//     reset  asynchronous active-high reset; aborts a frame and releases the line
//     bus    sdio_cmd_response_tx_if.slave (payload, strobe, CMD pad, status)
//
//   Parameter:
//     RESP_DELAY  capture edge to start bit, 1..15 cycles
//
//   Build option:
//     SDIO_CMD_TX_HOLD_EN  when defined, a one-deep holding register keeps one
//                          request that arrives while busy and launches it on
//                          the release edge; otherwise such requests are
//                          dropped with an overrun pulse.
module sdio_cmd_response_tx #(
  parameter int RESP_DELAY = 2
) (
  input logic                   clock,
  input logic                   reset,
  sdio_cmd_response_tx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  localparam logic [3:0] DELAY_LOAD  = 4'(RESP_DELAY - 1);
  localparam state_t     FIRST_STATE = (RESP_DELAY == 1) ? SEND : WAIT;

  state_t      state;
  logic [3:0]  delay_cnt;
  logic [5:0]  bit_cnt;
  logic [38:0] shreg;
  logic [6:0]  crc;
  logic        r4;

  logic        cmd_out_q;
  logic        cmd_oe_q;
  logic        busy_q;
  logic        tx_done_q;
  logic        overrun_q;

  logic        strobe;
  logic        release_edge;
  logic        capture;
  logic        capture_hold;
  logic        overrun_evt;
  logic        tx_bit;
  logic [37:0] cap_data;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  assign strobe       = bus.write_data_strobe;
  assign release_edge = (state == SEND) && (bit_cnt == 6'd48);

`ifdef SDIO_CMD_TX_HOLD_EN
  logic        hold_full;
  logic [37:0] hold_data;
  logic        hold_accept;

  // On the release edge the held request is consumed, so a strobe arriving
  // on that same edge may refill the holding register.
  assign capture_hold = release_edge && hold_full;
  assign hold_accept  = strobe && (state != IDLE) && (!hold_full || capture_hold);
  assign overrun_evt  = strobe && (state != IDLE) && !hold_accept;
  assign cap_data     = capture_hold ? hold_data : bus.write_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
    end else if (hold_accept) begin
      hold_full <= 1'b1;
    end else if (capture_hold) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (hold_accept) begin
      hold_data <= bus.write_data;
    end
  end
`else
  assign capture_hold = 1'b0;
  assign overrun_evt  = strobe && (state != IDLE);
  assign cap_data     = bus.write_data;
`endif

  assign capture = ((state == IDLE) && strobe) || capture_hold;

  // Bit to drive at the current SEND edge, indexed by frame position.
  always_comb begin
    tx_bit = 1'b1;
    if (bit_cnt == 6'd0) begin
      tx_bit = 1'b0;
    end else if (bit_cnt <= 6'd39) begin
      tx_bit = shreg[38];
    end else if (bit_cnt <= 6'd46) begin
      tx_bit = r4 | crc[6];
    end
  end

  // Datapath: payload shifter and CRC; no reset needed, always reloaded on capture.
  always_ff @(posedge clock) begin
    if (capture) begin
      shreg <= {1'b0, cap_data};
      r4    <= &cap_data[37:32];
    end else if ((state == SEND) && (bit_cnt >= 6'd1) && (bit_cnt <= 6'd39)) begin
      shreg <= {shreg[37:0], 1'b0};
    end

    if (state == SEND) begin
      if (bit_cnt == 6'd0) begin
        crc <= crc7_step(7'd0, 1'b0);
      end else if (bit_cnt <= 6'd39) begin
        crc <= crc7_step(crc, shreg[38]);
      end else if (bit_cnt <= 6'd46) begin
        crc <= {crc[5:0], 1'b0};
      end
    end
  end

  // Control FSM with registered pad and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      delay_cnt <= 4'd0;
      bit_cnt   <= 6'd0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      overrun_q <= overrun_evt;
      case (state)
        IDLE: begin
          if (strobe) begin
            busy_q    <= 1'b1;
            delay_cnt <= DELAY_LOAD;
            bit_cnt   <= 6'd0;
            state     <= FIRST_STATE;
          end
        end
        WAIT: begin
          // Leaving on count 1 makes the first SEND edge land on E0+RESP_DELAY.
          if (delay_cnt <= 4'd1) begin
            state <= SEND;
          end else begin
            delay_cnt <= delay_cnt - 4'd1;
          end
        end
        SEND: begin
          if (release_edge) begin
            cmd_oe_q  <= 1'b0;
            cmd_out_q <= 1'b1;
            tx_done_q <= 1'b1;
            bit_cnt   <= 6'd0;
            if (capture_hold) begin
              delay_cnt <= DELAY_LOAD;
              state     <= FIRST_STATE;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            cmd_oe_q  <= 1'b1;
            cmd_out_q <= tx_bit;
            bit_cnt   <= bit_cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_out                  = cmd_out_q;
  assign bus.cmd_oe                   = cmd_oe_q;
  assign bus.send_command_in_progress = busy_q;
  assign bus.tx_done                  = tx_done_q;
  assign bus.overrun                  = overrun_q;

endmodule
